// File: rtl/operand_bypass_net.sv
// Operand-delivery stage between ID and EX.
// Latches NUM_PORTS register-file read ports into ID_EX operand registers,
// resolves priority-ordered bypass sources per port, captures bypassed values
// into the operand registers while ID_EX is stalled, and muxes register,
// immediate or next-PC data onto each source bus. Also pipes store data to
// EX_DM and keeps a sticky multi-hit diagnostic.
//
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   stall_ID_EX       hold operand registers (bypass capture still allowed)
//   stall_EX_DM       hold st_data_EX_DM
//   flush_ID_EX       zero the operand registers (overrides stall)
//   src_sel_ID_EX     2 bits per port: 00 fwd, 01 sx imm[11:0], 10 sx imm[7:0],
//                     11 pc (NPC_PORT) or sx imm[15:0] (other ports)
//   rf_rd             register-file read data, DW per port
//   imm_ID_EX         instruction immediate
//   pc_ID_EX          next PC for JAL
//   byp_data          bypass values, DW per source (source 0 youngest)
//   byp_sel           NUM_BYP select bits per port
//   src               combinational source buses to EX
//   st_data_EX_DM     registered store data
//   byp_multi_hit     sticky: some port saw more than one select bit
module operand_bypass_net #(
    parameter int unsigned DW         = 32,
    parameter int unsigned NUM_PORTS  = 2,
    parameter int unsigned NUM_BYP    = 4,
    parameter int unsigned NPC_PORT   = 1,
    parameter int unsigned STORE_PORT = 0
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         stall_ID_EX,
    input  logic                         stall_EX_DM,
    input  logic                         flush_ID_EX,
    input  logic [2*NUM_PORTS-1:0]       src_sel_ID_EX,
    input  logic [DW*NUM_PORTS-1:0]      rf_rd,
    input  logic [15:0]                  imm_ID_EX,
    input  logic [DW-1:0]                pc_ID_EX,
    input  logic [DW*NUM_BYP-1:0]        byp_data,
    input  logic [NUM_BYP*NUM_PORTS-1:0] byp_sel,
    output logic [DW*NUM_PORTS-1:0]      src,
    output logic [DW-1:0]                st_data_EX_DM,
    output logic                         byp_multi_hit
);

    logic [DW-1:0]        op  [NUM_PORTS];
    logic [DW-1:0]        fwd [NUM_PORTS];
    logic [NUM_PORTS-1:0] hit;
    logic [NUM_PORTS-1:0] multi;
    logic [DW-1:0]        imm12_sx;
    logic [DW-1:0]        imm8_sx;
    logic [DW-1:0]        imm16_sx;

    // Sign-extended immediate variants shared by all ports
    assign imm12_sx = {{(DW-12){imm_ID_EX[11]}}, imm_ID_EX[11:0]};
    assign imm8_sx  = {{(DW-8){imm_ID_EX[7]}},   imm_ID_EX[7:0]};
    assign imm16_sx = {{(DW-16){imm_ID_EX[15]}}, imm_ID_EX[15:0]};

    // Bypass resolution: lowest-indexed set select wins, else operand register
    always_comb begin
        logic [NUM_BYP-1:0] sel_p;
        logic               found;
        sel_p = '0;
        found = 1'b0;
        hit   = '0;
        multi = '0;
        for (int unsigned p = 0; p < NUM_PORTS; p++) begin
            sel_p  = byp_sel[NUM_BYP*p +: NUM_BYP];
            found  = 1'b0;
            fwd[p] = op[p];
            for (int unsigned b = 0; b < NUM_BYP; b++) begin
                if (sel_p[b] && !found) begin
                    fwd[p] = byp_data[DW*b +: DW];
                    found  = 1'b1;
                end
            end
            hit[p]   = |sel_p;
            // Clearing the lowest set bit leaves a nonzero value iff >= 2 bits set
            multi[p] = |(sel_p & (sel_p - NUM_BYP'(1)));
        end
    end

    // Source bus muxes
    always_comb begin
        src = '0;
        for (int unsigned p = 0; p < NUM_PORTS; p++) begin
            unique case (src_sel_ID_EX[2*p +: 2])
                2'b00:   src[DW*p +: DW] = fwd[p];
                2'b01:   src[DW*p +: DW] = imm12_sx;
                2'b10:   src[DW*p +: DW] = imm8_sx;
                default: src[DW*p +: DW] = (p == NPC_PORT) ? pc_ID_EX : imm16_sx;
            endcase
        end
    end

    // Operand registers, store-data pipe and sticky multi-hit flag
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned p = 0; p < NUM_PORTS; p++) begin
                op[p] <= '0;
            end
            st_data_EX_DM <= '0;
            byp_multi_hit <= 1'b0;
        end else begin
            for (int unsigned p = 0; p < NUM_PORTS; p++) begin
                if (flush_ID_EX) begin
                    op[p] <= '0;
                end else if (!stall_ID_EX) begin
                    op[p] <= rf_rd[DW*p +: DW];
                end else if (hit[p]) begin
                    // Capture so a producer leaving the bypass window is not lost
                    op[p] <= fwd[p];
                end
            end
            if (!stall_EX_DM) begin
                st_data_EX_DM <= fwd[STORE_PORT];
            end
            byp_multi_hit <= byp_multi_hit | (|multi);
        end
    end

endmodule

// File: doc/operand_bypass_net.md
Name: operand_bypass_net

Overview:
- Parametrised operand-delivery stage between ID and EX of the in-order superscalar CPU.
- Latches NUM_PORTS register-file read ports into ID_EX operand registers.
- Resolves an arbitrary number of priority-ordered bypass sources per port, then selects register, immediate or next-PC data onto each source bus.
- Unlike the single-issue two-port mux, bypassed values are captured into the operand register while ID_EX is stalled, so a producer leaving the bypass window during a stall cannot lose its result. The stage also supports flush and flags multi-hit bypass selects.

Parameters:
DW, 32, datapath width (minimum 16)
NUM_PORTS, 2, number of operand ports / source buses
NUM_BYP, 4, number of bypass sources; index 0 is the youngest and has highest priority
NPC_PORT, 1, port whose select value 2'b11 chooses pc_ID_EX; on all other ports 2'b11 selects sign-extended imm[15:0]
STORE_PORT, 0, port whose resolved RF value is piped to EX_DM as store data

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
stall_ID_EX  in  1  holds the ID_EX operand registers (bypass capture still allowed)
stall_EX_DM  in  1  holds st_data_EX_DM
flush_ID_EX  in  1  kills the instruction entering or sitting in ID_EX
src_sel_ID_EX  in  2*NUM_PORTS  per-port source select; port p uses bits [2p+1:2p]
rf_rd  in  DW*NUM_PORTS  register-file read data, port p uses [DW*p +: DW]
imm_ID_EX  in  16  instruction immediate
pc_ID_EX  in  DW  next PC for JAL
byp_data  in  DW*NUM_BYP  bypass source values, source b uses [DW*b +: DW]
byp_sel  in  NUM_BYP*NUM_PORTS  from ID, one bit per (port,source); port p uses [NUM_BYP*p +: NUM_BYP]
src  out  DW*NUM_PORTS  source buses to EX
st_data_EX_DM  out  DW  store data for the DM stage
byp_multi_hit  out  1  sticky diagnostic: some port had more than one byp_sel bit set in a cycle

Behaviour:
- The module has one clock domain. Reset is synchronous and active-low: on a clk edge with rst_n=0, all operand registers, st_data_EX_DM and byp_multi_hit are cleared to 0.
- Resolved RF value for port p, fwd[p], is combinational:
  - the byp_data of the lowest-indexed set bit in port p's byp_sel slice;
  - if no bit is set, the operand register op[p].
- op[p] update on each clk edge (rst_n=1), highest priority first:
  1. flush_ID_EX=1 -> op[p] <= 0. Flush overrides stall.
  2. stall_ID_EX=0 -> op[p] <= rf_rd[p].
  3. stall_ID_EX=1 and any byp_sel bit for port p set -> op[p] <= fwd[p] (capture).
  4. otherwise hold.
- Capture contract: while stalled, ID keeps byp_sel asserted only while the source is valid. After capture ID may deassert byp_sel, and fwd[p] keeps presenting the captured value.
- src[p] is combinational, selected by src_sel[p]:
  - 00 -> fwd[p]
  - 01 -> sign-extended imm[11:0] (branch/jump)
  - 10 -> sign-extended imm[7:0] (DM address, ADDI/SUBI)
  - 11 -> pc_ID_EX if p==NPC_PORT, else sign-extended imm[15:0] (LLB/LHB)
  - All sign extension is to DW bits.
- st_data_EX_DM:
  - on a clk edge with stall_EX_DM=0, st_data_EX_DM <= fwd[STORE_PORT];
  - otherwise it holds;
  - it is not affected by flush_ID_EX.
- byp_multi_hit:
  - set on the clk edge after any cycle in which a port has two or more byp_sel bits set;
  - stays set until reset;
  - the datapath still uses priority resolution in that cycle.
- Latency:
  - RF read to src: 1 cycle.
  - Bypass to src: 0 cycles.
  - fwd to st_data_EX_DM: 1 cycle.
- Reset asserted during a stall clears everything; there is no stall memory after reset.

Test Plan:
1. Reset, then rf_rd port0=0x11, port1=0x22, no stall, sel=00 -> next cycle src0=0x11, src1=0x22, st_data 0 until one edge later, then 0x11.
2. byp_sel port0 bits 0 and 2 set, byp_data0=0xAAAA, byp_data2=0xCCCC -> src0=0xAAAA in the same cycle; byp_multi_hit=1 from the next edge and stays 1 until rst_n=0.
3. stall_ID_EX=1 with port1 byp_sel bit3 set, byp_data3=0x1234 for one cycle, then deasserted with the stall held 3 cycles -> src1=0x1234 throughout; on stall release op1 loads the new rf_rd.
4. imm_ID_EX=0x0F80: sel=01 -> 0xFFFFFF80? No: imm[11:0]=0xF80 gives 0xFFFFFF80; sel=10 gives 0xFFFFFF80; port0 sel=11 gives 0x00000F80; port1 sel=11 with pc_ID_EX=0x40 gives 0x40.
5. flush_ID_EX=1 together with stall_ID_EX=1 and rf_rd=0x55 -> op0 and op1 become 0, so src with sel=00 reads 0; st_data_EX_DM is unchanged.
6. stall_EX_DM=1 while fwd0 changes 0x7->0x9 -> st_data holds the old value; on release it updates to 0x9 one edge later. With DW=64, NUM_PORTS=3, NUM_BYP=6, sign extension is checked at the 64-bit width.
